// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FTDI UART receive path.
//   uart_rx_state_t      receiver FSM states
//   UART_DATA_BITS       payload bits per frame
//   CLKS_PER_BIT_115200  12 MHz board clock / 115200 baud
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int CLKS_PER_BIT_115200 = 104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// N-stage metastability synchroniser for an asynchronous single-bit input.
// All flops reset to 1, so an idle-high serial line reads as idle straight
// out of reset.
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  synchronised output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver for the FTDI serial link (8N1, or 8E1 when the build macro
// UART_RX_PARITY_EN is defined). Bytes land in a one-entry holding register
// read through a valid/ready handshake.
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   ftdi_rx     in   serial input, idle high, asynchronous to clk
//   rx_data     out  received byte, stable while rx_valid is high
//   rx_valid    out  holding register full
//   rx_ready    in   consumer takes the byte when rx_valid && rx_ready
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   overrun     out  one-cycle pulse: byte dropped, holding register full
//   busy        out  FSM not in IDLE
//   parity_err  out  (UART_RX_PARITY_EN only) one-cycle pulse: bad parity
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ftdi_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic rx_s;

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      byte_done;
    logic                      cnt_tick;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q, par_bad_d;
    logic                      parity_err_q, parity_err_d;
`endif

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ftdi_rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;
        cnt_tick    = (cnt_q == CNT_LAST);
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_tick) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_tick) begin
                    cnt_d        = '0;
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_bad_d    = (^shift_q) ^ rx_s;
                    parity_err_d = (^shift_q) ^ rx_s;
                    state_d      = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Leave at mid-stop so a back-to-back start edge is seen.
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        byte_done = !par_bad_q;
`else
                        byte_done = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // Wait out a held-low line instead of decoding it as 0x00 frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
